bti_banked_sram: RTL and testbench

BTI-attached on-chip memory: the parametrised successor of the single-bank BTI SRAM slave. It splits the word space across NBANK word-interleaved SRAM banks and buffers responses in a credit-managed FIFO, so response back-pressure never loses read data. It range- and alignment-checks every request, answering bad ones with ok=0. It sits on the BTI fabric as a slave, alongside other memory/peripheral slaves.

---
 rtl/bti_banked_sram_if.sv | 33 +++
 rtl/bti_banked_sram.sv | 175 +++++++++++++++++
 tb/tb_bti_banked_sram.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bti_banked_sram_if.sv
// BTI fabric definitions shared by the banked SRAM slave and its users.
//   bti_pkg      : command encodings.
//   bti_req_if_t : request channel (vld/rdy + pkt{cmd, addr, data, tid}).
//   bti_rsp_if_t : response channel (vld/rdy + pkt{tid, data, ok}).
package bti_pkg;
  localparam logic BTI_CMD_READ  = 1'b0;
  localparam logic BTI_CMD_WRITE = 1'b1;
endpackage

interface bti_req_if_t #(parameter int AW = 32, parameter int DW = 32, parameter int TW = 4);
  logic vld;
  logic rdy;
  struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tid;
  } pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

interface bti_rsp_if_t #(parameter int DW = 32, parameter int TW = 4);
  logic vld;
  logic rdy;
  struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic          ok;
  } pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

// File: rtl/bti_banked_sram.sv
// bti_banked_sram: BTI slave backed by NBANK word-interleaved SRAM banks.
// Requests are range/alignment checked, the selected bank is accessed in the
// accept cycle, and the completed response is captured one cycle later into
// a RSP_DEPTH-entry FIFO. Credit (occ) covers the stage register plus the
// FIFO, so response back-pressure can never overflow the FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bti_req_slv  : request channel (slave side)
//   bti_rsp_mst  : response channel (master side)

// One SRAM bank: synchronous write, registered read; contents not reset.
module bti_sram_bank #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (wen) mem[addr] <= wdata;
      else     rdata     <= mem[addr];
    end
  end
endmodule

module bti_banked_sram #(
  parameter int BTI_AW    = 32,
  parameter int BTI_DW    = 32,
  parameter int SRAM_AW   = 15,
  parameter int NBANK     = 2,
  parameter int RSP_DEPTH = 4,
  parameter int TIDW      = 4
) (
  input logic      clk,
  input logic      rst_n,
  bti_req_if_t.slv bti_req_slv,
  bti_rsp_if_t.mst bti_rsp_mst
);
  import bti_pkg::*;

  localparam int BW  = $clog2(NBANK);
  localparam int SBW = (BW > 0) ? BW : 1;       // keeps bank fields non-empty at NBANK=1
  localparam int RW  = SRAM_AW - BW;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [TIDW-1:0]   tid;
    logic [BTI_DW-1:0] data;
    logic              ok;
  } rsp_t;

  // ---------------- decode ----------------
  logic [SRAM_AW-1:0] word;
  logic [SBW-1:0]     bank;
  logic [RW-1:0]      row;
  logic               err, req_rdy, accept, wen;
  logic [NBANK-1:0]   bank_cs;
  logic [NBANK-1:0][BTI_DW-1:0] bank_rdata;

  assign word = bti_req_slv.pkt.addr[SRAM_AW+1:2];
  assign bank = (NBANK > 1) ? SBW'(word) : '0;
  assign row  = RW'(word >> BW);
  assign err  = (bti_req_slv.pkt.addr[1:0] != 2'b00) |
                ((bti_req_slv.pkt.addr >> (SRAM_AW + 2)) != '0);
  assign wen  = (bti_req_slv.pkt.cmd == BTI_CMD_WRITE);

  logic [CW-1:0] occ;
  assign req_rdy         = (occ < CW'(RSP_DEPTH));
  assign bti_req_slv.rdy = req_rdy;
  assign accept          = bti_req_slv.vld & req_rdy;

  always_comb begin
    bank_cs = '0;
    if (accept && !err) bank_cs[bank] = 1'b1;
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    bti_sram_bank #(.AW(RW), .DW(BTI_DW)) u_bank (
      .clk   (clk),
      .cs    (bank_cs[g]),
      .wen   (wen),
      .addr  (row),
      .wdata (bti_req_slv.pkt.data),
      .rdata (bank_rdata[g])
    );
  end

  // ---------------- stage s1 ----------------
  logic            s1_vld, s1_wr, s1_err;
  logic [TIDW-1:0] s1_tid;
  logic [SBW-1:0]  s1_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_wr   <= 1'b0;
      s1_err  <= 1'b0;
      s1_tid  <= '0;
      s1_bank <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_wr   <= wen;
        s1_err  <= err;
        s1_tid  <= bti_req_slv.pkt.tid;
        s1_bank <= bank;
      end
    end
  end

  rsp_t s1_rsp;
  always_comb begin
    s1_rsp      = '0;
    s1_rsp.tid  = s1_tid;
    s1_rsp.ok   = !s1_err;
    s1_rsp.data = (s1_err || s1_wr) ? '0 : bank_rdata[s1_bank];
  end

  // ---------------- response FIFO ----------------
  rsp_t          fifo [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt;
  logic          push, pop;

  assign push            = s1_vld;
  assign pop             = (fcnt != '0) & bti_rsp_mst.rdy;
  assign bti_rsp_mst.vld = (fcnt != '0);
  assign bti_rsp_mst.pkt = fifo[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= s1_rsp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
      // push only moves an entry from s1 into the FIFO; credit is unaffected
      case ({accept, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && fcnt == CW'(RSP_DEPTH)));
      assert (occ <= CW'(RSP_DEPTH));
    end
  end
endmodule

// File: tb/tb_bti_banked_sram.sv
// Self-checking bench for bti_banked_sram: directed scenarios plus a random
// vld/rdy run, all checked against a behavioural memory/response model.
module tb_bti_banked_sram;
  localparam int AW = 32, DW = 32, SAW = 15, NB = 2, DEPTH = 4, TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bti_req_if_t #(.AW(AW), .DW(DW), .TW(TW)) rq ();
  bti_rsp_if_t #(.DW(DW), .TW(TW)) rs ();

  bti_banked_sram #(.BTI_AW(AW), .BTI_DW(DW), .SRAM_AW(SAW), .NBANK(NB),
                    .RSP_DEPTH(DEPTH), .TIDW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bti_req_slv(rq), .bti_rsp_mst(rs));

  typedef struct packed { logic [TW-1:0] tid; logic [DW-1:0] data; logic ok; } rsp_t;
  typedef struct packed { logic cmd; logic [AW-1:0] addr; logic [DW-1:0] data; logic [TW-1:0] tid; } req_t;

  rsp_t          exp_q [$];
  req_t          pend  [$];
  logic [DW-1:0] mem   [int];
  int ntests = 0, nfail = 0, mocc = 0;

  function automatic bit bad_addr(input logic [AW-1:0] a);
    return (a % 4 != 0) || (64'(a) >= (64'(1) << (SAW + 2)));
  endfunction

  function automatic logic [NB-1:0] exp_cs(input logic [AW-1:0] a);
    if (bad_addr(a)) return '0;
    return NB'(1) << ((a / 4) % NB);
  endfunction

  function automatic void model_acc(input req_t r);
    rsp_t e;
    e.tid = r.tid; e.ok = !bad_addr(r.addr); e.data = '0;
    if (e.ok) begin
      if (r.cmd) mem[int'(r.addr / 4)] = r.data;
      else       e.data = mem[int'(r.addr / 4)];
    end
    exp_q.push_back(e);
    mocc++;
  endfunction

  function automatic bit exp_pop(output rsp_t e);
    e = '0;
    if (exp_q.size() == 0) return 1'b0;
    e = exp_q.pop_front();
    mocc--;
    return 1'b1;
  endfunction

  task automatic drive_next();
    req_t r;
    if (pend.size() != 0) begin
      r = pend.pop_front();
      rq.vld = 1'b1; rq.pkt.cmd = r.cmd; rq.pkt.addr = r.addr;
      rq.pkt.data = r.data; rq.pkt.tid = r.tid;
    end else rq.vld = 1'b0;
  endtask

  // One clock: sample at the falling edge, update the model, advance.
  task automatic tick(output bit acc, output bit pop, output rsp_t pkt,
                      output logic [NB-1:0] cs, output req_t accd);
    @(negedge clk);
    acc  = rq.vld && rq.rdy;
    pop  = rs.vld && rs.rdy;
    pkt  = rs.pkt;
    cs   = dut.bank_cs;
    accd = {rq.pkt.cmd, rq.pkt.addr, rq.pkt.data, rq.pkt.tid};
    if (acc) model_acc(accd);
    @(posedge clk); #1;
    if (acc) drive_next();
  endtask

  function automatic req_t mk(input logic c, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [TW-1:0] t);
    return {c, a, d, t};
  endfunction

  bit acc, pop; rsp_t pkt, e; logic [NB-1:0] cs; req_t accd;

  task automatic test_reset();
    rst_n = 1'b0; rq.vld = 1'b0; rs.rdy = 1'b0;
    rq.pkt = '0;
    repeat (3) @(posedge clk);
    #1;
    ntests++; if (rq.rdy !== 1'b1) begin nfail++; $display("FAIL reset_rdy got %b want 1", rq.rdy); end
    ntests++; if (rs.vld !== 1'b0) begin nfail++; $display("FAIL reset_vld got %b want 0", rs.vld); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int first_pop = -1, npop = 0;
    rs.rdy = 1'b1;
    pend.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3));
    pend.push_back(mk(0, 32'h10, 32'h0, 4));
    drive_next();
    for (int i = 0; i < 20 && npop < 2; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (acc) begin
        ntests++;
        if (cs !== exp_cs(accd.addr)) begin nfail++; $display("FAIL basic_cs got %b want %b", cs, exp_cs(accd.addr)); end
      end
      if (pop) begin
        if (first_pop < 0) first_pop = i;
        npop++; ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL basic_rsp got %h want %h", pkt, e); end
      end
    end
    ntests++; if (first_pop != 2) begin nfail++; $display("FAIL basic_latency got %0d want 2", first_pop); end
    ntests++; if (npop != 2) begin nfail++; $display("FAIL basic_count got %0d want 2", npop); end
  endtask

  task automatic test_interleave();
    int first_pop = -1, last_pop = -1, npop = 0;
    rs.rdy = 1'b1;
    for (int i = 0; i < 8; i++) pend.push_back(mk(1, AW'(i * 4), DW'(32'h100 + i), TW'(i)));
    for (int i = 0; i < 8; i++) pend.push_back(mk(0, AW'(i * 4), '0, TW'(8 + i)));
    drive_next();
    for (int i = 0; i < 60 && npop < 16; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (acc) begin
        ntests++;
        if (cs !== exp_cs(accd.addr)) begin nfail++; $display("FAIL ilv_cs got %b want %b", cs, exp_cs(accd.addr)); end
      end
      if (pop) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i; npop++; ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL ilv_rsp got %h want %h", pkt, e); end
      end
    end
    ntests++; if (npop != 16 || last_pop - first_pop != 15) begin
      nfail++; $display("FAIL ilv_rate got pops=%0d span=%0d want 16/15", npop, last_pop - first_pop);
    end
  endtask

  task automatic test_errors();
    int npop = 0;
    rs.rdy = 1'b1;
    pend.push_back(mk(0, 32'h0000_0002, '0, 1));
    pend.push_back(mk(1, 32'h0002_0000, 32'hBAD0BAD0, 2));
    pend.push_back(mk(0, 32'h0000_0000, '0, 3));
    drive_next();
    for (int i = 0; i < 20 && npop < 3; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (acc) begin
        ntests++;
        if (cs !== exp_cs(accd.addr)) begin nfail++; $display("FAIL err_cs got %b want %b", cs, exp_cs(accd.addr)); end
      end
      if (pop) begin
        npop++; ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL err_rsp got %h want %h", pkt, e); end
      end
    end
    ntests++; if (npop != 3) begin nfail++; $display("FAIL err_count got %0d want 3", npop); end
  endtask

  task automatic test_backpressure();
    int nacc = 0, npop = 0, first_pop = -1;
    rs.rdy = 1'b0;
    for (int i = 0; i < 6; i++) pend.push_back(mk(0, AW'(i * 4), '0, TW'(8 + i)));
    drive_next();
    for (int i = 0; i < 12; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (acc) nacc++;
    end
    ntests++; if (nacc != DEPTH) begin nfail++; $display("FAIL bp_accepts got %0d want %0d", nacc, DEPTH); end
    ntests++; if (rq.rdy !== 1'b0) begin nfail++; $display("FAIL bp_rdy got %b want 0", rq.rdy); end
    rs.rdy = 1'b1;
    for (int i = 0; i < 30 && npop < 6; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (acc) nacc++;
      if (first_pop >= 0 && i == first_pop + 1) begin
        ntests++; if (!acc) begin nfail++; $display("FAIL bp_rdy_rise got acc=%b want 1", acc); end
      end
      if (pop) begin
        if (first_pop < 0) first_pop = i;
        npop++; ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL bp_rsp got %h want %h", pkt, e); end
      end
    end
    ntests++; if (npop != 6 || nacc != 6) begin nfail++; $display("FAIL bp_total got pops=%0d accs=%0d want 6/6", npop, nacc); end
  endtask

  task automatic test_random();
    bit   hold = 1'b0;
    rsp_t held = '0;
    logic [AW-1:0] a;
    for (int i = 0; i < 1000; i++) begin
      rs.rdy = ($urandom_range(0, 9) < 6);
      rq.vld = $urandom_range(0, 1);
      a = AW'($urandom_range(0, 7) * 4);
      case ($urandom_range(0, 7))
        0: a = a | AW'($urandom_range(1, 3));
        1: a = a | 32'h0002_0000;
        default: ;
      endcase
      rq.pkt.cmd = $urandom_range(0, 1); rq.pkt.addr = a;
      rq.pkt.data = $urandom; rq.pkt.tid = TW'($urandom);
      #1;
      ntests++; if (rq.rdy !== (mocc < DEPTH)) begin nfail++; $display("FAIL rnd_rdy got %b want %b", rq.rdy, mocc < DEPTH); end
      ntests++; if (int'(dut.occ) != mocc) begin nfail++; $display("FAIL rnd_occ got %0d want %0d", dut.occ, mocc); end
      if (hold) begin
        ntests++; if (rs.vld !== 1'b1 || rs.pkt !== held) begin nfail++; $display("FAIL rnd_stable got %h want %h", rs.pkt, held); end
      end
      hold = rs.vld && !rs.rdy; held = rs.pkt;
      tick(acc, pop, pkt, cs, accd);
      if (pop) begin
        ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL rnd_rsp got %h want %h", pkt, e); end
      end
    end
    rq.vld = 1'b0; rs.rdy = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (pop) begin
        ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL rnd_drain got %h want %h", pkt, e); end
      end
    end
    ntests++; if (exp_q.size() != 0 || rs.vld !== 1'b0) begin
      nfail++; $display("FAIL rnd_leftover got %0d pending vld=%b want 0", exp_q.size(), rs.vld);
    end
  endtask

  task automatic test_reset_mid();
    int npop = 0;
    rs.rdy = 1'b0;
    for (int i = 0; i < 3; i++) pend.push_back(mk(0, AW'(i * 4), '0, TW'(i)));
    drive_next();
    repeat (6) tick(acc, pop, pkt, cs, accd);
    #2 rst_n = 1'b0;
    #1;
    ntests++; if (rs.vld !== 1'b0) begin nfail++; $display("FAIL rstmid_vld got %b want 0", rs.vld); end
    ntests++; if (rq.rdy !== 1'b1) begin nfail++; $display("FAIL rstmid_rdy got %b want 1", rq.rdy); end
    exp_q.delete(); pend.delete(); mocc = 0; rq.vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rs.rdy = 1'b1;
    pend.push_back(mk(0, 32'h14, '0, 7));
    drive_next();
    for (int i = 0; i < 20 && npop < 1; i++) begin
      tick(acc, pop, pkt, cs, accd);
      if (pop) begin
        npop++; ntests++;
        if (!exp_pop(e) || pkt !== e) begin nfail++; $display("FAIL rstmid_rsp got %h want %h", pkt, e); end
      end
    end
    ntests++; if (npop != 1) begin nfail++; $display("FAIL rstmid_count got %0d want 1", npop); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
